// File: rtl/mem_arbiter.sv
// Two-requester (instruction / data cache) arbiter onto one shared physical memory port.
// Optional round-robin tie-break when both request together: define MEM_ARB_RR_EN (default: data always wins).
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_I_BUSY,
        S_D_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner_d;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_d;

`ifdef MEM_ARB_RR_EN
    logic              r_last_d;
`endif

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        w_grant_d = w_d_req;
        if (w_d_req && w_i_req) begin
`ifdef MEM_ARB_RR_EN
            w_grant_d = ~r_last_d;
`else
            w_grant_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_state_next = w_grant_d ? S_D_BUSY : S_I_BUSY;
                end
            end
            S_I_BUSY, S_D_BUSY: begin
                if (pmem_resp) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Command, address and write line are captured once at grant; a simultaneous
    // read+write from the data cache is issued as a writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_d      <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_d       <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_i_req || w_d_req) begin
                        r_owner_d      <= w_grant_d;
                        r_pmem_write   <= w_grant_d & d_pmem_write;
                        r_pmem_read    <= ~(w_grant_d & d_pmem_write);
                        r_pmem_address <= w_grant_d ? d_pmem_address : i_pmem_address;
                        r_pmem_wdata   <= w_grant_d ? d_pmem_wdata : '0;
`ifdef MEM_ARB_RR_EN
                        r_last_d       <= w_grant_d;
`endif
                    end
                end
                S_I_BUSY, S_D_BUSY: begin
                    if (pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (r_state == S_D_BUSY) begin
                            r_d_rdata <= pmem_rdata;
                        end else begin
                            r_i_rdata <= pmem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign i_pmem_rdata = r_i_rdata;
    assign d_pmem_rdata = r_d_rdata;
    assign i_pmem_resp  = (r_state == S_DONE) && !r_owner_d;
    assign d_pmem_resp  = (r_state == S_DONE) &&  r_owner_d;

endmodule
